cdc_tx_scheduler: RTL and testbench

Source-side (clk domain) scheduler that feeds the tick/audio, cfg and play channels of the CDC unit. It accepts producer requests at any rate and re-times them so that each outgoing pulse is single-cycle, pulses respect the data synchronizer's minimum spacing, payloads stay stable until the next pulse, and play changes respect the bit synchronizer's hold time. It also buffers one early request per channel and flags overruns.

---
 rtl/cdc_tx_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_cdc_tx_scheduler.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_tx_scheduler.sv
// cdc_tx_scheduler: source-domain re-timer for the CDC unit's tick, cfg and play channels.
// Each data channel issues one-cycle pulses with frozen payloads. Consecutive pulses are at
// least DATA_INTERVAL cycles apart. One early request per channel is buffered, and a further
// request while that buffer is full sets a sticky overrun flag. play_out follows play_in and
// holds for BIT_INTERVAL cycles after every change.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   tick_req_in, dsp0/1_in     audio request pulse + 24-bit payloads
//   cfg_req_in, cfg_reg_in     config request pulse + 32-bit payload
//   play_in                    requested play level
//   clr_ovr_in                 clears both overrun flags (a new overrun wins)
//   tick_out, dsp0/1_out       audio pulse + payloads to the CDC
//   cfg_out, cfg_reg_out       config pulse + payload to the CDC
//   play_out                   rate-limited play level
//   tick_ovr_out, cfg_ovr_out  sticky overrun flags
//   busy_out                   any guard, pending entry or play hold active
module cdc_tx_scheduler #(
    parameter int unsigned DATA_INTERVAL = 4,  // CDC data-synchronizer interval
    parameter int unsigned BIT_INTERVAL  = 3   // CDC bit-synchronizer interval
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick_req_in,
    input  logic [23:0] dsp0_in,
    input  logic [23:0] dsp1_in,
    input  logic        cfg_req_in,
    input  logic [31:0] cfg_reg_in,
    input  logic        play_in,
    input  logic        clr_ovr_in,
    output logic        tick_out,
    output logic [23:0] dsp0_out,
    output logic [23:0] dsp1_out,
    output logic        cfg_out,
    output logic [31:0] cfg_reg_out,
    output logic        play_out,
    output logic        tick_ovr_out,
    output logic        cfg_ovr_out,
    output logic        busy_out
);

    localparam int unsigned GCW = $clog2(DATA_INTERVAL);
    localparam int unsigned HCW = $clog2(BIT_INTERVAL);
    localparam int unsigned TW  = 48;
    localparam int unsigned CW  = 32;

    typedef enum logic {S_IDLE = 1'b0, S_GUARD = 1'b1} ch_state_e;

    logic [1:0] ch_busy_c;

    // Channel 0 = tick/audio, channel 1 = cfg; identical logic, different payload width.
    for (genvar g = 0; g < 2; g++) begin : g_ch
        localparam int unsigned W = (g == 0) ? TW : CW;

        logic           req;
        logic [W-1:0]   din;
        ch_state_e      state, state_nxt;
        logic [GCW-1:0] cnt, cnt_nxt;
        logic           pend_v, pend_v_nxt;
        logic [W-1:0]   pend_d, pend_d_nxt;
        logic           issue_c;
        logic [W-1:0]   issue_d_c;
        logic           ovr_set_c;
        logic           pulse, pulse_nxt;
        logic [W-1:0]   payload, payload_nxt;
        logic           ovr, ovr_nxt;

        if (g == 0) begin : g_io
            assign req                  = tick_req_in;
            assign din                  = {dsp1_in, dsp0_in};
            assign tick_out             = pulse;
            assign {dsp1_out, dsp0_out} = payload;
            assign tick_ovr_out         = ovr;
        end else begin : g_io
            assign req          = cfg_req_in;
            assign din          = cfg_reg_in;
            assign cfg_out      = pulse;
            assign cfg_reg_out  = payload;
            assign cfg_ovr_out  = ovr;
        end

        // State, guard counter, pending buffer and output registers.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state   <= S_IDLE;
                cnt     <= '0;
                pend_v  <= 1'b0;
                pend_d  <= '0;
                pulse   <= 1'b0;
                payload <= '0;
                ovr     <= 1'b0;
            end else begin
                state   <= state_nxt;
                cnt     <= cnt_nxt;
                pend_v  <= pend_v_nxt;
                pend_d  <= pend_d_nxt;
                pulse   <= pulse_nxt;
                payload <= payload_nxt;
                ovr     <= ovr_nxt;
            end
        end

        // Next state. cnt==0 in GUARD is the last guard cycle: the decision made there
        // lands the next pulse exactly DATA_INTERVAL cycles after the previous one.
        always_comb begin
            state_nxt  = state;
            cnt_nxt    = cnt;
            pend_v_nxt = pend_v;
            pend_d_nxt = pend_d;
            issue_c    = 1'b0;
            issue_d_c  = din;
            ovr_set_c  = 1'b0;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        issue_c = 1'b1;
                    end
                end
                S_GUARD: begin
                    if (cnt == '0) begin
                        if (pend_v) begin
                            // Pending leaves this cycle, so a new request refills it freely.
                            issue_c    = 1'b1;
                            issue_d_c  = pend_d;
                            pend_v_nxt = req;
                            if (req) begin
                                pend_d_nxt = din;
                            end
                        end else if (req) begin
                            issue_c = 1'b1;
                        end else begin
                            state_nxt = S_IDLE;
                        end
                    end else begin
                        cnt_nxt = cnt - GCW'(1);
                        if (req) begin
                            if (!pend_v) begin
                                pend_v_nxt = 1'b1;
                                pend_d_nxt = din;
                            end else begin
                                ovr_set_c = 1'b1;
                            end
                        end
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
            if (issue_c) begin
                state_nxt = S_GUARD;
                cnt_nxt   = GCW'(DATA_INTERVAL - 1);
            end
        end

        // Outputs: one-cycle pulse, payload frozen between pulses, set-dominant overrun.
        always_comb begin
            pulse_nxt   = issue_c;
            payload_nxt = payload;
            if (issue_c) begin
                payload_nxt = issue_d_c;
            end
            ovr_nxt = ovr_set_c | (ovr & ~clr_ovr_in);
        end

        assign ch_busy_c[g] = (state_nxt == S_GUARD) | pend_v_nxt;
    end

    logic [HCW-1:0] hold, hold_nxt;
    logic           play_nxt;

    // Play follows play_in only once the hold has run out; hold==0 means free.
    always_comb begin
        play_nxt = play_out;
        hold_nxt = hold;
        if (hold == '0) begin
            if (play_in != play_out) begin
                play_nxt = play_in;
                hold_nxt = HCW'(BIT_INTERVAL - 1);
            end
        end else begin
            hold_nxt = hold - HCW'(1);
        end
    end

    // Play and busy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            play_out <= 1'b0;
            hold     <= '0;
            busy_out <= 1'b0;
        end else begin
            play_out <= play_nxt;
            hold     <= hold_nxt;
            busy_out <= (|ch_busy_c) | (hold_nxt != '0);
        end
    end

endmodule

// File: tb/tb_cdc_tx_scheduler.sv
// tb_cdc_tx_scheduler: directed, table-driven bench for cdc_tx_scheduler (DATA_INTERVAL=6,
// BIT_INTERVAL=4) plus hand-written overrun, clear-priority and async-reset sequences.
module tb_cdc_tx_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tick_req_in, cfg_req_in, play_in, clr_ovr_in;
    logic [23:0] dsp0_in, dsp1_in;
    logic [31:0] cfg_reg_in;
    logic        tick_out, cfg_out, play_out, tick_ovr_out, cfg_ovr_out, busy_out;
    logic [23:0] dsp0_out, dsp1_out;
    logic [31:0] cfg_reg_out;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    cdc_tx_scheduler #(.DATA_INTERVAL(6), .BIT_INTERVAL(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .tick_req_in(tick_req_in), .dsp0_in(dsp0_in), .dsp1_in(dsp1_in),
        .cfg_req_in(cfg_req_in), .cfg_reg_in(cfg_reg_in),
        .play_in(play_in), .clr_ovr_in(clr_ovr_in),
        .tick_out(tick_out), .dsp0_out(dsp0_out), .dsp1_out(dsp1_out),
        .cfg_out(cfg_out), .cfg_reg_out(cfg_reg_out), .play_out(play_out),
        .tick_ovr_out(tick_ovr_out), .cfg_ovr_out(cfg_ovr_out), .busy_out(busy_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        tick_req, cfg_req, play, clr;
        logic [23:0] d0, d1;
        logic [31:0] cr;
        logic        e_tick, e_cfg, e_play, e_tovr, e_covr, e_busy;
        logic [23:0] e_d0, e_d1;
        logic [31:0] e_cr;
    } vec_t;

    vec_t vecs[$];

    localparam logic [23:0] SA_D0 = 24'h123456, SA_D1 = 24'hABCDEF;
    localparam logic [31:0] SA_CR = 32'hDEADBEEF;
    localparam logic [23:0] J0 = 24'h5A5A5A, J1 = 24'hA5A5A5;
    localparam logic [31:0] JC = 32'h0F0F0F0F;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic idle_inputs();
        tick_req_in = 1'b0; cfg_req_in = 1'b0; clr_ovr_in = 1'b0;
        dsp0_in = J0; dsp1_in = J1; cfg_reg_in = JC;
    endtask

    function automatic vec_t mk(input logic tr, input logic crq, input logic pl, input logic cl,
                                input logic [23:0] d0, input logic [23:0] d1, input logic [31:0] cr,
                                input logic et, input logic ec, input logic ep, input logic eto,
                                input logic eco, input logic eb, input logic [23:0] ed0,
                                input logic [23:0] ed1, input logic [31:0] ecr);
        vec_t v;
        v.tick_req = tr; v.cfg_req = crq; v.play = pl; v.clr = cl;
        v.d0 = d0; v.d1 = d1; v.cr = cr;
        v.e_tick = et; v.e_cfg = ec; v.e_play = ep; v.e_tovr = eto; v.e_covr = eco; v.e_busy = eb;
        v.e_d0 = ed0; v.e_d1 = ed1; v.e_cr = ecr;
        return v;
    endfunction

    initial begin
        logic [23:0] pd0 [3];
        logic [23:0] pd1 [3];
        logic        pin  [17];
        logic        ppo  [17];
        logic        pbsy [17];
        logic [31:0] xc   [3];
        logic [23:0] y0   [3];

        pd0 = '{24'h00A0A0, 24'h00B0B0, 24'h00C0C0};
        pd1 = '{24'h0A0A0A, 24'h0B0B0B, 24'h0C0C0C};
        pin  = '{1,1,0,1,1,0,0,0,0, 1,1,0,1,0,0,0,0};
        ppo  = '{1,1,1,1,1,0,0,0,0, 1,1,1,1,0,0,0,0};
        pbsy = '{1,1,1,0,0,1,1,1,0, 1,1,1,0,1,1,1,0};
        xc   = '{32'h11110001, 32'h22220002, 32'h33330003};
        y0   = '{24'h000777, 24'h000888, 24'h000999};

        // Single simultaneous tick+cfg request; busy for the pulse cycle plus 5 guard cycles.
        for (int i = 0; i < 8; i++) begin
            logic r;
            r = (i == 0);
            vecs.push_back(mk(r, r, 1'b0, 1'b0, r ? SA_D0 : J0, r ? SA_D1 : J1, r ? SA_CR : JC,
                              r, r, 1'b0, 1'b0, 1'b0, (i <= 5), SA_D0, SA_D1, SA_CR));
        end
        // Requests at 0, 2, 6: pulses at 1, 7, 13; the request at 6 lands as pending issues.
        for (int i = 0; i < 20; i++) begin
            logic r;
            int   k;
            int   e;
            r = (i == 0) || (i == 2) || (i == 6);
            k = (i == 0) ? 0 : ((i == 2) ? 1 : 2);
            e = (i < 6) ? 0 : ((i < 12) ? 1 : 2);
            vecs.push_back(mk(r, 1'b0, 1'b0, 1'b0, r ? pd0[k] : J0, r ? pd1[k] : J1, JC,
                              (i == 0) || (i == 6) || (i == 12), 1'b0, 1'b0, 1'b0, 1'b0,
                              (i <= 17), pd0[e], pd1[e], SA_CR));
        end
        // Play hold: toggles inside the hold are lost, the last value wins afterwards.
        for (int i = 0; i < 17; i++) begin
            vecs.push_back(mk(1'b0, 1'b0, pin[i], 1'b0, J0, J1, JC, 1'b0, 1'b0, ppo[i],
                              1'b0, 1'b0, pbsy[i], pd0[2], pd1[2], SA_CR));
        end

        rst_n = 1'b0;
        play_in = 1'b0;
        idle_inputs();
        #1;
        step();
        step();
        chk("rst.tick", 32'(tick_out), 32'h0);
        chk("rst.cfg", 32'(cfg_out), 32'h0);
        chk("rst.play", 32'(play_out), 32'h0);
        chk("rst.busy", 32'(busy_out), 32'h0);
        chk("rst.dsp0", 32'(dsp0_out), 32'h0);
        chk("rst.ovr", 32'({tick_ovr_out, cfg_ovr_out}), 32'h0);
        rst_n = 1'b1;
        step();
        step();

        foreach (vecs[i]) begin
            tick_req_in = vecs[i].tick_req; cfg_req_in = vecs[i].cfg_req;
            play_in = vecs[i].play; clr_ovr_in = vecs[i].clr;
            dsp0_in = vecs[i].d0; dsp1_in = vecs[i].d1; cfg_reg_in = vecs[i].cr;
            step();
            chk($sformatf("vec%0d.tick", i), 32'(tick_out), 32'(vecs[i].e_tick));
            chk($sformatf("vec%0d.cfg", i), 32'(cfg_out), 32'(vecs[i].e_cfg));
            chk($sformatf("vec%0d.play", i), 32'(play_out), 32'(vecs[i].e_play));
            chk($sformatf("vec%0d.tovr", i), 32'(tick_ovr_out), 32'(vecs[i].e_tovr));
            chk($sformatf("vec%0d.covr", i), 32'(cfg_ovr_out), 32'(vecs[i].e_covr));
            chk($sformatf("vec%0d.busy", i), 32'(busy_out), 32'(vecs[i].e_busy));
            chk($sformatf("vec%0d.dsp0", i), 32'(dsp0_out), 32'(vecs[i].e_d0));
            chk($sformatf("vec%0d.dsp1", i), 32'(dsp1_out), 32'(vecs[i].e_d1));
            chk($sformatf("vec%0d.cfgreg", i), 32'(cfg_reg_out), vecs[i].e_cr);
        end

        // cfg overrun: requests at 0, 2, 4; third dropped; flag 5..10; clear at 10.
        for (int r = 0; r < 15; r++) begin
            idle_inputs();
            if (r == 0 || r == 2 || r == 4) begin
                cfg_req_in = 1'b1;
                cfg_reg_in = xc[r / 2];
            end
            clr_ovr_in = (r == 10);
            step();
            chk($sformatf("ovr%0d.cfg", r), 32'(cfg_out), 32'((r + 1 == 1) || (r + 1 == 7)));
            chk($sformatf("ovr%0d.cfgreg", r), cfg_reg_out, (r + 1 < 7) ? xc[0] : xc[1]);
            chk($sformatf("ovr%0d.covr", r), 32'(cfg_ovr_out), 32'((r + 1 >= 5) && (r + 1 <= 10)));
        end

        // tick overrun coinciding with clear: the set wins and the flag stays.
        for (int r = 0; r < 15; r++) begin
            idle_inputs();
            if (r <= 2) begin
                tick_req_in = 1'b1;
                dsp0_in = y0[r];
            end
            clr_ovr_in = (r == 2);
            step();
            chk($sformatf("setwin%0d.tick", r), 32'(tick_out), 32'((r + 1 == 1) || (r + 1 == 7)));
            chk($sformatf("setwin%0d.dsp0", r), 32'(dsp0_out), 32'((r + 1 < 7) ? y0[0] : y0[1]));
            chk($sformatf("setwin%0d.tovr", r), 32'(tick_ovr_out), 32'(r + 1 >= 3));
        end

        // Async reset while pending is valid, then no pulse until a fresh request.
        idle_inputs();
        play_in = 1'b1;
        step();
        step();
        tick_req_in = 1'b1; dsp0_in = 24'h0000D1;
        step();
        idle_inputs();
        step();
        tick_req_in = 1'b1; dsp0_in = 24'h0000D2;
        step();
        idle_inputs();
        chk("pre_reset.busy", 32'(busy_out), 32'h1);
        chk("pre_reset.play", 32'(play_out), 32'h1);
        rst_n = 1'b0;
        play_in = 1'b0;
        #2;
        chk("async_rst.tick", 32'(tick_out), 32'h0);
        chk("async_rst.dsp0", 32'(dsp0_out), 32'h0);
        chk("async_rst.cfgreg", cfg_reg_out, 32'h0);
        chk("async_rst.play", 32'(play_out), 32'h0);
        chk("async_rst.tovr", 32'(tick_ovr_out), 32'h0);
        chk("async_rst.busy", 32'(busy_out), 32'h0);
        step();
        rst_n = 1'b1;
        for (int r = 0; r < 10; r++) begin
            step();
            chk($sformatf("post_rst%0d.tick", r), 32'(tick_out), 32'h0);
            chk($sformatf("post_rst%0d.busy", r), 32'(busy_out), 32'h0);
        end
        tick_req_in = 1'b1; dsp0_in = 24'h0000D3;
        step();
        idle_inputs();
        chk("first_after_rst.tick", 32'(tick_out), 32'h1);
        chk("first_after_rst.dsp0", 32'(dsp0_out), 32'h0000D3);
        step();
        chk("first_after_rst.width", 32'(tick_out), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
